// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types for the memory access stage.
//   - access size encodings (byte/half/word)
//   - FSM state enum
//   - MEM/WB output record
//   - ld_extend(): byte/half selection plus sign/zero extension of a load word
package mem_stage_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic {IDLE, WAIT} state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        branch;
    logic        mispredict;
    logic        fault;
    logic [31:0] pc;
  } out_rec_t;

  // Shift the addressed byte/half down to bit 0, then extend.
  function automatic logic [31:0] ld_extend(input logic [31:0] word,
                                            input logic [1:0]  off,
                                            input logic [1:0]  sz,
                                            input logic        uns);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (sz)
      SZ_B:    ld_extend = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    ld_extend = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: ld_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/data_ram.sv
// data_ram: DEPTH x XLEN data memory with per-byte write enables.
//   i_clk   : write clock
//   i_we    : byte-lane write enables (lane b covers bits 8b+7..8b)
//   i_waddr : word write index,  i_wdata : write data (already lane-replicated)
//   i_raddr : word read index,   o_rdata : combinational read data
// No reset: contents survive rst_n.
module data_ram #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic [3:0]        i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [XLEN-1:0]   o_rdata
);

  logic [XLEN-1:0] r_mem [DEPTH];

  for (genvar b = 0; b < 4; b++) begin : g_lane
    always_ff @(posedge i_clk) begin
      if (i_we[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline memory stage between EX/MEM and write-back.
//   Input side : i_in_valid/o_in_ready handshake carrying a load/store/branch op
//                (i_mem_read, i_mem_write, i_branch_en, i_size, i_ld_unsigned,
//                i_zero, i_pred_taken, i_addr, i_wdata, i_pc), i_flush kill.
//   Output side: MEM/WB register o_out_valid/i_out_ready with o_out_rdata,
//                o_out_branch, o_out_mispredict, o_out_fault, o_out_pc.
// Loads with LATENCY>1 park in WAIT until the read completes; only one op
// is ever outstanding.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic            i_mem_read,
  input  logic            i_mem_write,
  input  logic            i_branch_en,
  input  logic [1:0]      i_size,
  input  logic            i_ld_unsigned,
  input  logic            i_zero,
  input  logic            i_pred_taken,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_out_rdata,
  output logic            o_out_branch,
  output logic            o_out_mispredict,
  output logic            o_out_fault,
  output logic [XLEN-1:0] o_out_pc
);

  localparam int AW = $clog2(DEPTH);
  // Number of extra WAIT cycles after the accept cycle.
  localparam int CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;

  state_e          r_state, w_state_n;
  logic [1:0]      r_cnt, w_cnt_n;
  logic            r_out_valid;
  out_rec_t        r_out, w_rec;
  logic            w_out_load;

  // Fields of a load parked in WAIT.
  logic [AW-1:0]   r_addr;
  logic [1:0]      r_off, r_size;
  logic            r_uns, r_branch, r_mispred;
  logic [XLEN-1:0] r_pc;

  logic            w_accept, w_fault, w_is_load, w_branch, w_mispred;
  logic [3:0]      w_we;
  logic [XLEN-1:0] w_wdata, w_rdword;
  logic [AW-1:0]   w_raddr;

  assign o_in_ready = (r_state == IDLE) & (!r_out_valid | i_out_ready) & !i_flush;
  assign w_accept   = i_in_valid & o_in_ready;

  assign w_fault = (i_size == 2'd3)
                 | (i_mem_read & i_mem_write)
                 | ((i_size == SZ_H) & i_addr[0])
                 | ((i_size == SZ_W) & (i_addr[1:0] != 2'b00))
                 | ((i_addr >> (AW + 2)) != '0);

  assign w_is_load = i_mem_read & !w_fault;
  assign w_branch  = i_branch_en & i_zero;
  assign w_mispred = i_branch_en & (w_branch ^ i_pred_taken);

  // Store lane enables and lane-replicated write data.
  always_comb begin
    w_we    = 4'b0000;
    w_wdata = i_wdata;
    case (i_size)
      SZ_B: begin
        w_we    = 4'b0001 << i_addr[1:0];
        w_wdata = {4{i_wdata[7:0]}};
      end
      SZ_H: begin
        w_we    = i_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_wdata[15:0]}};
      end
      default: w_we = 4'b1111;
    endcase
    if (!(w_accept & i_mem_write & !w_fault)) w_we = 4'b0000;
  end

  // In WAIT the read port follows the parked address.
  assign w_raddr = (r_state == WAIT) ? r_addr : i_addr[AW+1:2];

  data_ram #(.XLEN(XLEN), .DEPTH(DEPTH)) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (i_addr[AW+1:2]),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdword)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_out_load = 1'b0;
    w_rec      = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_is_load && LATENCY > 1) begin
            w_state_n = WAIT;
            w_cnt_n   = 2'(CNT_INIT);
          end else begin
            w_out_load       = 1'b1;
            w_rec.rdata      = w_fault   ? '0 :
                               w_is_load ? ld_extend(w_rdword, i_addr[1:0], i_size, i_ld_unsigned)
                                         : i_addr;
            w_rec.branch     = w_branch;
            w_rec.mispredict = w_mispred;
            w_rec.fault      = w_fault;
            w_rec.pc         = i_pc;
          end
        end
      end
      WAIT: begin
        if (r_cnt != 2'd0) begin
          w_cnt_n = r_cnt - 2'd1;
        end else if (!r_out_valid | i_out_ready) begin
          w_out_load       = 1'b1;
          w_rec.rdata      = ld_extend(w_rdword, r_off, r_size, r_uns);
          w_rec.branch     = r_branch;
          w_rec.mispredict = r_mispred;
          w_rec.pc         = r_pc;
          w_state_n        = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
    if (i_flush) begin
      w_state_n  = IDLE;
      w_cnt_n    = 2'd0;
      w_out_load = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else begin
      if (i_flush)          r_out_valid <= 1'b0;
      else if (w_out_load)  r_out_valid <= 1'b1;
      else if (i_out_ready) r_out_valid <= 1'b0;
      if (w_out_load) r_out <= w_rec;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr    <= '0;
      r_off     <= 2'd0;
      r_size    <= 2'd0;
      r_uns     <= 1'b0;
      r_branch  <= 1'b0;
      r_mispred <= 1'b0;
      r_pc      <= '0;
    end else if (w_accept & w_is_load) begin
      r_addr    <= i_addr[AW+1:2];
      r_off     <= i_addr[1:0];
      r_size    <= i_size;
      r_uns     <= i_ld_unsigned;
      r_branch  <= w_branch;
      r_mispred <= w_mispred;
      r_pc      <= i_pc;
    end
  end

  assign o_out_valid      = r_out_valid;
  assign o_out_rdata      = r_out.rdata;
  assign o_out_branch     = r_out.branch;
  assign o_out_mispredict = r_out.mispredict;
  assign o_out_fault      = r_out.fault;
  assign o_out_pc         = r_out.pc;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam int XLEN = 32, DEPTH = 1024, LATENCY = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 0, in_ready, mem_read = 0, mem_write = 0, branch_en = 0;
  logic [1:0] size = 0;
  logic ld_unsigned = 0, zero = 0, pred_taken = 0, flush = 0;
  logic [31:0] addr = 0, wdata = 0, pc = 0;
  logic out_valid, out_ready = 1, out_branch, out_mispredict, out_fault;
  logic [31:0] out_rdata, out_pc;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_mem_read(mem_read), .i_mem_write(mem_write), .i_branch_en(branch_en),
    .i_size(size), .i_ld_unsigned(ld_unsigned), .i_zero(zero),
    .i_pred_taken(pred_taken), .i_addr(addr), .i_wdata(wdata), .i_pc(pc),
    .i_flush(flush), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_rdata(out_rdata), .o_out_branch(out_branch),
    .o_out_mispredict(out_mispredict), .o_out_fault(out_fault), .o_out_pc(out_pc)
  );

  // Present an op and hold it until accepted; returns #1 after the accept edge.
  task automatic send(input logic rd, input logic wr, input logic br,
                      input logic [1:0] sz, input logic uns, input logic z,
                      input logic pt, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] p);
    bit ok = 0;
    mem_read = rd; mem_write = wr; branch_en = br; size = sz; ld_unsigned = uns;
    zero = z; pred_taken = pt; addr = a; wdata = wd; pc = p; in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0b after 20 cycles, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    #12;
    n_tests++;
    if ({out_valid, out_rdata, out_branch, out_mispredict, out_fault, out_pc} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%0b rdata=%h pc=%h, required all 0", out_valid, out_rdata, out_pc);
    end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
  endtask

  task automatic test_store_load;
    send(0, 1, 0, 2'd2, 0, 0, 0, 32'h10, 32'hDEADBEEF, 32'h0);
    n_tests++;
    if (out_valid !== 1 || out_rdata !== 32'h10 || out_fault !== 0) begin
      n_fail++; $display("FAIL store_result: valid=%0b rdata=%h fault=%0b, required 1/00000010/0", out_valid, out_rdata, out_fault);
    end
    send(1, 0, 0, 2'd2, 0, 0, 0, 32'h10, 32'h0, 32'h20);
    n_tests++;
    if (out_valid !== 0) begin n_fail++; $display("FAIL load_early: valid=%0b required 0 one cycle after accept", out_valid); end
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1 || out_rdata !== 32'hDEADBEEF || out_fault !== 0 || out_pc !== 32'h20) begin
      n_fail++; $display("FAIL load_word: valid=%0b rdata=%h fault=%0b pc=%h, required 1/deadbeef/0/00000020", out_valid, out_rdata, out_fault, out_pc);
    end
  endtask

  task automatic test_extension;
    logic [31:0] a [5]   = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h11};
    logic [1:0]  s [5]   = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
    logic        u [5]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] e [5]   = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD, 32'hFFFFFFBE};
    for (int i = 0; i < 5; i++) begin
      send(1, 0, 0, s[i], u[i], 0, 0, a[i], 32'h0, 32'h0);
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1 || out_rdata !== e[i] || out_fault !== 0) begin
        n_fail++; $display("FAIL ext_load_%0d: valid=%0b rdata=%h required %h", i, out_valid, out_rdata, e[i]);
      end
    end
  endtask

  task automatic test_fault;
    send(0, 1, 0, 2'd2, 0, 0, 0, 32'h4, 32'h12345678, 32'h0);
    send(0, 1, 0, 2'd2, 0, 0, 0, 32'h6, 32'hFFFFFFFF, 32'h0);
    n_tests++;
    if (out_valid !== 1 || out_fault !== 1 || out_rdata !== 0) begin
      n_fail++; $display("FAIL misaligned_store: valid=%0b fault=%0b rdata=%h, required 1/1/0", out_valid, out_fault, out_rdata);
    end
    send(1, 0, 0, 2'd2, 0, 0, 0, 32'h4, 32'h0, 32'h0);
    @(posedge clk); #1;
    n_tests++;
    if (out_rdata !== 32'h12345678 || out_fault !== 0) begin
      n_fail++; $display("FAIL no_write_on_fault: rdata=%h fault=%0b required 12345678/0", out_rdata, out_fault);
    end
    // Faulting loads complete like non-loads: result the cycle after accept.
    send(1, 0, 0, 2'd2, 0, 0, 0, 4 * DEPTH, 32'h0, 32'h0);
    n_tests++;
    if (out_valid !== 1 || out_fault !== 1 || out_rdata !== 0) begin
      n_fail++; $display("FAIL out_of_range: valid=%0b fault=%0b rdata=%h required 1/1/0", out_valid, out_fault, out_rdata);
    end
    send(1, 0, 0, 2'd1, 0, 0, 0, 32'h11, 32'h0, 32'h0);
    n_tests++;
    if (out_fault !== 1 || out_rdata !== 0) begin n_fail++; $display("FAIL misaligned_half: fault=%0b rdata=%h required 1/0", out_fault, out_rdata); end
    send(1, 1, 0, 2'd2, 0, 0, 0, 32'h8, 32'h0, 32'h0);
    n_tests++;
    if (out_fault !== 1) begin n_fail++; $display("FAIL read_and_write: fault=%0b required 1", out_fault); end
    send(0, 0, 0, 2'd3, 0, 0, 0, 32'h8, 32'h0, 32'h0);
    n_tests++;
    if (out_fault !== 1) begin n_fail++; $display("FAIL reserved_size: fault=%0b required 1", out_fault); end
  endtask

  task automatic test_branch;
    logic z [3]  = '{1'b1, 1'b1, 1'b0};
    logic pt [3] = '{1'b0, 1'b1, 1'b1};
    logic eb [3] = '{1'b1, 1'b1, 1'b0};
    logic em [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      send(0, 0, 1, 2'd2, 0, z[i], pt[i], 32'h80, 32'h0, 32'h40);
      n_tests++;
      if (out_branch !== eb[i] || out_mispredict !== em[i] || out_pc !== 32'h40 || out_rdata !== 32'h80) begin
        n_fail++; $display("FAIL branch_%0d: br=%0b mis=%0b pc=%h rdata=%h, required %0b/%0b/00000040/00000080", i, out_branch, out_mispredict, out_pc, out_rdata, eb[i], em[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    send(0, 0, 0, 2'd2, 0, 0, 0, 32'h54, 32'h0, 32'h100);
    out_ready = 0;
    mem_read = 1; mem_write = 0; branch_en = 0; size = 2'd2; addr = 32'h10; pc = 32'h104;
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (in_ready !== 0 || out_valid !== 1 || out_rdata !== 32'h54 || out_pc !== 32'h100) begin
        n_fail++; $display("FAIL hold_%0d: in_ready=%0b valid=%0b rdata=%h pc=%h, required 0/1/00000054/00000100", i, in_ready, out_valid, out_rdata, out_pc);
      end
    end
    out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    n_tests++;
    if (out_valid !== 0) begin n_fail++; $display("FAIL drain: valid=%0b required 0", out_valid); end
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1 || out_rdata !== 32'hDEADBEEF || out_pc !== 32'h104) begin
      n_fail++; $display("FAIL load_after_drain: valid=%0b rdata=%h pc=%h required 1/deadbeef/00000104", out_valid, out_rdata, out_pc);
    end
  endtask

  task automatic test_flush;
    send(1, 0, 0, 2'd2, 0, 0, 0, 32'h10, 32'h0, 32'h0);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    n_tests++;
    if (out_valid !== 0) begin n_fail++; $display("FAIL flush_wait: valid=%0b required 0", out_valid); end
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 0 || in_ready !== 1) begin
      n_fail++; $display("FAIL flush_idle: valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
    end
    send(0, 0, 0, 2'd2, 0, 0, 0, 32'h3C, 32'h0, 32'h0);
    out_ready = 0;
    @(posedge clk); #1;
    flush = 1;
    @(posedge clk); #1;
    flush = 0; out_ready = 1;
    n_tests++;
    if (out_valid !== 0) begin n_fail++; $display("FAIL flush_output: valid=%0b required 0", out_valid); end
  endtask

  task automatic test_reset_midwait;
    send(1, 0, 0, 2'd2, 0, 0, 0, 32'h10, 32'h0, 32'h50);
    #1 rst_n = 0;
    #1;
    n_tests++;
    if (out_valid !== 0 || out_rdata !== 0 || out_pc !== 0 || out_fault !== 0) begin
      n_fail++; $display("FAIL reset_midwait: valid=%0b rdata=%h pc=%h required 0/0/0", out_valid, out_rdata, out_pc);
    end
    @(negedge clk); rst_n = 1;
    send(1, 0, 0, 2'd2, 0, 0, 0, 32'h10, 32'h0, 32'h60);
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1 || out_rdata !== 32'hDEADBEEF || out_pc !== 32'h60) begin
      n_fail++; $display("FAIL after_reset_load: valid=%0b rdata=%h pc=%h required 1/deadbeef/00000060", out_valid, out_rdata, out_pc);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_extension();
    test_fault();
    test_branch();
    test_backpressure();
    test_flush();
    test_reset_midwait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
